// File: rtl/dispatch_pkg.sv
// Shared definitions for the dispatch memory block: default geometry,
// dispatch word field positions and the spy access state encoding.
package dispatch_pkg;

    localparam int DISP_AW = 11;
    localparam int DISP_DW = 17;

    // Dispatch word layout: {R, N, P, PC[13:0]}
    localparam int DISP_PC_LSB = 0;
    localparam int DISP_PC_MSB = 13;
    localparam int DISP_P      = 14;
    localparam int DISP_N      = 15;
    localparam int DISP_R      = 16;

    typedef enum logic [1:0] {
        SPY_IDLE  = 2'd0,
        SPY_ISSUE = 2'd1,
        SPY_RDATA = 2'd2,
        SPY_ACK   = 2'd3
    } spy_state_t;

endpackage

// File: rtl/dispatch_wbuf.sv
// Single-entry dispatch write buffer with read-address compare; the forward
// flag and data are registered at the read grant so they line up with ram_rdata.
module dispatch_wbuf import dispatch_pkg::*; #(
    parameter int AW = DISP_AW,
    parameter int DW = DISP_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          retire,
    input  logic          rd_gnt,
    input  logic [AW-1:0] rd_addr,
    output logic          pw_valid,
    output logic [AW-1:0] pw_addr,
    output logic [DW-1:0] pw_data,
    output logic          fwd,
    output logic [DW-1:0] fwd_data
);

    logic accept;
    logic hit;

    // A full buffer refuses writes, so retire and capture never share a cycle.
    assign accept = wr_req && !pw_valid;
    assign hit    = rd_gnt && pw_valid && (pw_addr == rd_addr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pw_valid <= 1'b0;
            pw_addr  <= '0;
            pw_data  <= '0;
        end else if (retire) begin
            pw_valid <= 1'b0;
        end else if (accept) begin
            pw_valid <= 1'b1;
            pw_addr  <= wr_addr;
            pw_data  <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd      <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd <= hit;
            if (hit) begin
                fwd_data <= pw_data;
            end
        end
    end

endmodule

// File: rtl/dispatch_mem_arb.sv
// Dispatch memory arbiter: lookup, buffered microcode write and spy port share
// one synchronous single-port RAM, one grant per cycle.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  SPY_IDLE  | no spy access in progress
//  SPY_ISSUE | spy request waiting for a RAM grant
//  SPY_RDATA | spy read granted, RAM data arrives this cycle
//  SPY_ACK   | spy_ack high until spy_req drops
module dispatch_mem_arb import dispatch_pkg::*; #(
    parameter int AW         = DISP_AW,
    parameter int DW         = DISP_DW,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          lk_req,
    input  logic [AW-1:0] lk_addr,
    output logic          lk_valid,
    output logic [DW-1:0] lk_data,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_busy,
    input  logic          spy_req,
    input  logic          spy_we,
    input  logic [AW-1:0] spy_addr,
    input  logic [DW-1:0] spy_wdata,
    output logic          spy_ack,
    output logic [DW-1:0] spy_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    spy_state_t    spy_state;
    spy_state_t    spy_next;
    logic [SW-1:0] starve_cnt;

    logic          pw_valid;
    logic [AW-1:0] pw_addr;
    logic [DW-1:0] pw_data;
    logic          fwd;
    logic [DW-1:0] fwd_data;

    logic          spy_issue;
    logic          starved;
    logic          spy_gnt;
    logic          wr_gnt;
    logic          rd_gnt;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_result;

    assign spy_issue = (spy_state == SPY_ISSUE) && spy_req;
    assign starved   = (starve_cnt == STARVE_TOP);
    assign spy_gnt   = !lk_req && spy_issue && (starved || !pw_valid);
    assign wr_gnt    = !lk_req && pw_valid && !(spy_issue && starved);
    assign rd_gnt    = lk_req || (spy_gnt && !spy_we);
    assign rd_addr   = lk_req ? lk_addr : spy_addr;
    assign rd_result = fwd ? fwd_data : ram_rdata;
    assign wr_busy   = pw_valid;

    dispatch_wbuf #(
        .AW (AW),
        .DW (DW)
    ) u_wbuf (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .retire   (wr_gnt),
        .rd_gnt   (rd_gnt),
        .rd_addr  (rd_addr),
        .pw_valid (pw_valid),
        .pw_addr  (pw_addr),
        .pw_data  (pw_data),
        .fwd      (fwd),
        .fwd_data (fwd_data)
    );

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (lk_req) begin
            ram_addr = lk_addr;
        end else if (spy_gnt) begin
            ram_addr  = spy_addr;
            ram_we    = spy_we;
            ram_wdata = spy_we ? spy_wdata : '0;
        end else if (wr_gnt) begin
            ram_addr  = pw_addr;
            ram_we    = 1'b1;
            ram_wdata = pw_data;
        end
    end

    // Only losses to the pending write count; losing to a lookup holds the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (spy_gnt) begin
            starve_cnt <= '0;
        end else if (spy_issue && pw_valid && !lk_req && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spy_state <= SPY_IDLE;
        end else begin
            spy_state <= spy_next;
        end
    end

    always_comb begin
        spy_next = spy_state;
        spy_ack  = 1'b0;
        case (spy_state)
            SPY_IDLE: begin
                if (spy_req) spy_next = SPY_ISSUE;
            end
            SPY_ISSUE: begin
                if (!spy_req)     spy_next = SPY_IDLE;
                else if (spy_gnt) spy_next = spy_we ? SPY_ACK : SPY_RDATA;
            end
            SPY_RDATA: begin
                spy_next = SPY_ACK;
            end
            SPY_ACK: begin
                spy_ack = 1'b1;
                if (!spy_req) spy_next = SPY_IDLE;
            end
            default: begin
                spy_next = SPY_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lk_valid  <= 1'b0;
            spy_rdata <= '0;
        end else begin
            lk_valid <= lk_req;
            if (spy_state == SPY_RDATA) begin
                spy_rdata <= rd_result;
            end
        end
    end

    assign lk_data = lk_valid ? rd_result : '0;

endmodule

// File: tb/tb_dispatch_mem_arb.sv
// Directed bench for dispatch_mem_arb with a synchronous RAM model; table
// vectors for lookup/write timing plus sequences for spy, starvation and reset.
module tb_dispatch_mem_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        lk_req;
    logic [10:0] lk_addr;
    logic        lk_valid;
    logic [16:0] lk_data;
    logic        wr_req;
    logic [10:0] wr_addr;
    logic [16:0] wr_data;
    logic        wr_busy;
    logic        spy_req;
    logic        spy_we;
    logic [10:0] spy_addr;
    logic [16:0] spy_wdata;
    logic        spy_ack;
    logic [16:0] spy_rdata;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [16:0] ram_wdata;
    logic [16:0] ram_rdata;

    logic        ram_clr;
    logic [16:0] mem [0:2047];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dispatch_mem_arb #(.AW(11), .DW(17), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .lk_req    (lk_req),
        .lk_addr   (lk_addr),
        .lk_valid  (lk_valid),
        .lk_data   (lk_data),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_busy   (wr_busy),
        .spy_req   (spy_req),
        .spy_we    (spy_we),
        .spy_addr  (spy_addr),
        .spy_wdata (spy_wdata),
        .spy_ack   (spy_ack),
        .spy_rdata (spy_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 2048; i++) mem[i] <= '0;
            ram_rdata <= '0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        logic        lk_req;
        logic [10:0] lk_addr;
        logic        wr_req;
        logic [10:0] wr_addr;
        logic [16:0] wr_data;
        logic        e_lk_valid;
        logic [16:0] e_lk_data;
        logic        e_wr_busy;
        logic        e_ram_we;
        logic [10:0] e_ram_addr;
        logic [16:0] e_ram_wdata;
    } vec_t;

    vec_t vt [20];

    function automatic vec_t mk(input logic lr, input logic [10:0] la,
                                input logic wr, input logic [10:0] wa, input logic [16:0] wd,
                                input logic ev, input logic [16:0] ed, input logic eb,
                                input logic ew, input logic [10:0] ea, input logic [16:0] ewd);
        vec_t v;
        v.lk_req = lr;  v.lk_addr = la;
        v.wr_req = wr;  v.wr_addr = wa;  v.wr_data = wd;
        v.e_lk_valid = ev;  v.e_lk_data = ed;  v.e_wr_busy = eb;
        v.e_ram_we = ew;    v.e_ram_addr = ea; v.e_ram_wdata = ewd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic lookup_chk(input logic [10:0] a, input logic [16:0] exp, input string nm);
        tick();
        lk_req = 1'b1;
        lk_addr = a;
        tick();
        lk_req = 1'b0;
        sample();
        chk({nm, " lk_valid"}, 32'(lk_valid), 32'd1);
        chk({nm, " lk_data"}, 32'(lk_data), 32'(exp));
    endtask

    // Interleaves lookups with writes so the spy loses four times to a pending
    // write; the fifth pending write (last_addr) is where the spy must win.
    task automatic run_starve(input logic we, input logic [10:0] saddr, input logic [16:0] swd,
                              input logic [10:0] wbase, input logic [10:0] last_addr,
                              input logic [16:0] last_data, input logic [16:0] exp_rdata);
        tick();
        spy_req = 1'b1; spy_we = we; spy_addr = saddr; spy_wdata = swd;
        wr_req = 1'b1; wr_addr = wbase; wr_data = 17'h0A000;
        for (int i = 0; i < 4; i++) begin
            tick();
            wr_req = 1'b0;
            lk_req = 1'b0;
            sample();
            chk($sformatf("starve write%0d ram_we", i), 32'(ram_we), 32'd1);
            chk($sformatf("starve write%0d ram_addr", i), 32'(ram_addr), 32'(wbase + 11'(i)));
            chk($sformatf("starve cnt before loss%0d", i), 32'(dut.starve_cnt), 32'(i));
            tick();
            lk_req = 1'b1; lk_addr = 11'h000;
            wr_req = 1'b1;
            wr_addr = (i == 3) ? last_addr : wbase + 11'(i + 1);
            wr_data = (i == 3) ? last_data : 17'h0A000 + 17'(i + 1);
            sample();
            chk($sformatf("starve lookup%0d ram_we", i), 32'(ram_we), 32'd0);
            chk($sformatf("starve hold%0d cnt", i), 32'(dut.starve_cnt), 32'(i + 1));
        end
        tick();
        lk_req = 1'b0;
        wr_req = 1'b0;
        sample();
        chk("starve spy grant ram_addr", 32'(ram_addr), 32'(saddr));
        chk("starve spy grant ram_we", 32'(ram_we), 32'(we));
        chk("starve spy grant ram_wdata", 32'(ram_wdata), we ? 32'(swd) : 32'd0);
        chk("starve cnt at grant", 32'(dut.starve_cnt), 32'd4);
        tick();
        sample();
        chk("starve retire ram_we", 32'(ram_we), 32'd1);
        chk("starve retire ram_addr", 32'(ram_addr), 32'(last_addr));
        chk("starve retire ram_wdata", 32'(ram_wdata), 32'(last_data));
        chk("starve cnt cleared", 32'(dut.starve_cnt), 32'd0);
        chk("starve spy_ack after grant", 32'(spy_ack), 32'(we));
        if (!we) begin
            tick();
            sample();
            chk("starve read spy_ack", 32'(spy_ack), 32'd1);
            chk("starve read spy_rdata", 32'(spy_rdata), 32'(exp_rdata));
        end
        tick();
        spy_req = 1'b0;
        tick();
        sample();
        chk("starve spy_ack released", 32'(spy_ack), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; ram_clr = 1'b1;
        lk_req = 1'b0; lk_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        spy_req = 1'b0; spy_we = 1'b0; spy_addr = '0; spy_wdata = '0;

        //              lk  lk_addr  wr  wr_addr  wr_data    | v  lk_data    busy we ram_addr ram_wdata
        vt[0]  = mk(0, 11'h000, 1, 11'h123, 17'h1ABCD, 0, 17'h00000, 0, 0, 11'h000, 17'h00000);
        vt[1]  = mk(0, 11'h000, 0, 11'h000, 17'h00000, 0, 17'h00000, 1, 1, 11'h123, 17'h1ABCD);
        vt[2]  = mk(0, 11'h000, 0, 11'h000, 17'h00000, 0, 17'h00000, 0, 0, 11'h000, 17'h00000);
        vt[3]  = mk(0, 11'h000, 0, 11'h000, 17'h00000, 0, 17'h00000, 0, 0, 11'h000, 17'h00000);
        vt[4]  = mk(1, 11'h123, 0, 11'h000, 17'h00000, 0, 17'h00000, 0, 0, 11'h123, 17'h00000);
        vt[5]  = mk(0, 11'h000, 0, 11'h000, 17'h00000, 1, 17'h1ABCD, 0, 0, 11'h000, 17'h00000);
        vt[6]  = mk(0, 11'h000, 1, 11'h010, 17'h00042, 0, 17'h00000, 0, 0, 11'h000, 17'h00000);
        vt[7]  = mk(1, 11'h010, 0, 11'h000, 17'h00000, 0, 17'h00000, 1, 0, 11'h010, 17'h00000);
        vt[8]  = mk(0, 11'h000, 0, 11'h000, 17'h00000, 1, 17'h00042, 1, 1, 11'h010, 17'h00042);
        vt[9]  = mk(0, 11'h000, 0, 11'h000, 17'h00000, 0, 17'h00000, 0, 0, 11'h000, 17'h00000);
        vt[10] = mk(1, 11'h010, 0, 11'h000, 17'h00000, 0, 17'h00000, 0, 0, 11'h010, 17'h00000);
        vt[11] = mk(0, 11'h000, 0, 11'h000, 17'h00000, 1, 17'h00042, 0, 0, 11'h000, 17'h00000);
        vt[12] = mk(0, 11'h000, 1, 11'h055, 17'h15555, 0, 17'h00000, 0, 0, 11'h000, 17'h00000);
        vt[13] = mk(1, 11'h056, 0, 11'h000, 17'h00000, 0, 17'h00000, 1, 0, 11'h056, 17'h00000);
        vt[14] = mk(0, 11'h000, 1, 11'h066, 17'h00003, 1, 17'h00000, 1, 1, 11'h055, 17'h15555);
        vt[15] = mk(0, 11'h000, 0, 11'h000, 17'h00000, 0, 17'h00000, 0, 0, 11'h000, 17'h00000);
        vt[16] = mk(1, 11'h066, 0, 11'h000, 17'h00000, 0, 17'h00000, 0, 0, 11'h066, 17'h00000);
        vt[17] = mk(1, 11'h055, 0, 11'h000, 17'h00000, 1, 17'h00000, 0, 0, 11'h055, 17'h00000);
        vt[18] = mk(0, 11'h000, 0, 11'h000, 17'h00000, 1, 17'h15555, 0, 0, 11'h000, 17'h00000);
        vt[19] = mk(0, 11'h000, 0, 11'h000, 17'h00000, 0, 17'h00000, 0, 0, 11'h000, 17'h00000);

        repeat (2) @(posedge clk);
        sample();
        chk("reset lk_valid", 32'(lk_valid), 32'd0);
        chk("reset lk_data", 32'(lk_data), 32'd0);
        chk("reset wr_busy", 32'(wr_busy), 32'd0);
        chk("reset ram_we", 32'(ram_we), 32'd0);
        chk("reset ram_addr", 32'(ram_addr), 32'd0);
        chk("reset spy_ack", 32'(spy_ack), 32'd0);
        chk("reset spy_rdata", 32'(spy_rdata), 32'd0);
        chk("reset starve_cnt", 32'(dut.starve_cnt), 32'd0);
        tick();
        reset_n = 1'b1;
        ram_clr = 1'b0;

        for (int k = 0; k < 20; k++) begin
            tick();
            lk_req = vt[k].lk_req;  lk_addr = vt[k].lk_addr;
            wr_req = vt[k].wr_req;  wr_addr = vt[k].wr_addr;  wr_data = vt[k].wr_data;
            sample();
            chk($sformatf("vec%0d lk_valid", k), 32'(lk_valid), 32'(vt[k].e_lk_valid));
            chk($sformatf("vec%0d lk_data", k), 32'(lk_data), 32'(vt[k].e_lk_data));
            chk($sformatf("vec%0d wr_busy", k), 32'(wr_busy), 32'(vt[k].e_wr_busy));
            chk($sformatf("vec%0d ram_we", k), 32'(ram_we), 32'(vt[k].e_ram_we));
            chk($sformatf("vec%0d ram_addr", k), 32'(ram_addr), 32'(vt[k].e_ram_addr));
            chk($sformatf("vec%0d ram_wdata", k), 32'(ram_wdata), 32'(vt[k].e_ram_wdata));
        end

        // Spy read blocked by a continuous lookup stream.
        tick();
        wr_req = 1'b1; wr_addr = 11'h7FF; wr_data = 17'h0BEEF;
        tick();
        wr_req = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            lk_req = 1'b1; lk_addr = 11'(i + 1);
            spy_req = 1'b1; spy_we = 1'b0; spy_addr = 11'h7FF;
            sample();
            chk($sformatf("lkblock%0d ram_addr", i), 32'(ram_addr), 32'(i + 1));
            chk($sformatf("lkblock%0d starve_cnt", i), 32'(dut.starve_cnt), 32'd0);
            chk($sformatf("lkblock%0d spy_ack", i), 32'(spy_ack), 32'd0);
        end
        tick();
        lk_req = 1'b0;
        sample();
        chk("lkblock spy grant ram_addr", 32'(ram_addr), 32'h7FF);
        chk("lkblock spy grant ram_we", 32'(ram_we), 32'd0);
        tick();
        sample();
        chk("lkblock rdata spy_ack", 32'(spy_ack), 32'd0);
        tick();
        sample();
        chk("lkblock spy_ack", 32'(spy_ack), 32'd1);
        chk("lkblock spy_rdata", 32'(spy_rdata), 32'h0BEEF);
        tick();
        spy_req = 1'b0;
        tick();
        sample();
        chk("lkblock spy_ack released", 32'(spy_ack), 32'd0);

        // Starved spy write, then read everything back.
        run_starve(1'b1, 11'h200, 17'h1F00F, 11'h300, 11'h304, 17'h0A004, 17'h00000);
        for (int i = 0; i < 5; i++) begin
            lookup_chk(11'h300 + 11'(i), 17'h0A000 + 17'(i), $sformatf("readback%0d", i));
        end
        lookup_chk(11'h200, 17'h1F00F, "readback spy");

        // Starved spy read forwarded from the pending write to the same address.
        run_starve(1'b0, 11'h0AA, 17'h00000, 11'h0A0, 11'h0AA, 17'h1C3C3, 17'h1C3C3);
        lookup_chk(11'h0AA, 17'h1C3C3, "fwd readback");

        // Reset while a spy read is in RDATA and a write is pending.
        tick();
        spy_req = 1'b1; spy_we = 1'b0; spy_addr = 11'h150;
        tick();
        wr_req = 1'b1; wr_addr = 11'h151; wr_data = 17'h12345;
        sample();
        chk("rst setup spy grant", 32'(ram_addr), 32'h150);
        tick();
        wr_req = 1'b0;
        chk("rst setup pw_valid", 32'(dut.u_wbuf.pw_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst lk_valid", 32'(lk_valid), 32'd0);
        chk("midrst lk_data", 32'(lk_data), 32'd0);
        chk("midrst wr_busy", 32'(wr_busy), 32'd0);
        chk("midrst ram_we", 32'(ram_we), 32'd0);
        chk("midrst ram_addr", 32'(ram_addr), 32'd0);
        chk("midrst ram_wdata", 32'(ram_wdata), 32'd0);
        chk("midrst spy_ack", 32'(spy_ack), 32'd0);
        chk("midrst spy_rdata", 32'(spy_rdata), 32'd0);
        chk("midrst pw_valid", 32'(dut.u_wbuf.pw_valid), 32'd0);
        spy_req = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            sample();
            chk($sformatf("postrst%0d spy_ack", i), 32'(spy_ack), 32'd0);
            chk($sformatf("postrst%0d ram_we", i), 32'(ram_we), 32'd0);
        end
        lookup_chk(11'h151, 17'h00000, "dropped write");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
